// File: rtl/nlprg_period_chk.sv
// Period checker for an N-bit generator: measures the samples until the first one recurs, and flags stuck or overlong sequences.
// Optional feature NLPRG_PERIOD_CHK_ONES_EN adds ones_cnt and a balanced-MSB condition on pass.
module nlprg_period_chk #(
  parameter int N = 16
) (
  input  logic         ck,
  input  logic         rst,
  input  logic         start,
  input  logic         valid_in,
  input  logic [N-1:0] o_in,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic         stuck,
  output logic         timeout,
  output logic [N:0]   period
`ifdef NLPRG_PERIOD_CHK_ONES_EN
  ,
  output logic [N:0]   ones_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [N:0] FULL = {1'b1, {N{1'b0}}};
  localparam logic [N:0] ONE  = {{N{1'b0}}, 1'b1};

  state_t       state_r;
  logic [N:0]   cnt_r;
  logic [N-1:0] ref_r;
  logic [N-1:0] prev_r;
  logic         busy_r;
  logic         done_r;
  logic         pass_r;
  logic         stuck_r;
  logic         timeout_r;
  logic [N:0]   period_r;
  logic         ones_ok_s;

`ifdef NLPRG_PERIOD_CHK_ONES_EN
  localparam logic [N:0] HALF = {2'b01, {(N-1){1'b0}}};
  logic [N:0] ones_r;
  logic [N:0] msb_s;

  assign msb_s     = {{N{1'b0}}, o_in[N-1]};
  assign ones_ok_s = (ones_r == HALF);
  assign ones_cnt  = ones_r;
`else
  assign ones_ok_s = 1'b1;
`endif

  assign busy    = busy_r;
  assign done    = done_r;
  assign pass    = pass_r;
  assign stuck   = stuck_r;
  assign timeout = timeout_r;
  assign period  = period_r;

  // Measurement FSM with all result outputs registered alongside the state.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      cnt_r     <= {(N+1){1'b0}};
      ref_r     <= {N{1'b0}};
      prev_r    <= {N{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
      stuck_r   <= 1'b0;
      timeout_r <= 1'b0;
      period_r  <= {(N+1){1'b0}};
`ifdef NLPRG_PERIOD_CHK_ONES_EN
      ones_r    <= {(N+1){1'b0}};
`endif
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r   <= ARM;
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            stuck_r   <= 1'b0;
            timeout_r <= 1'b0;
            period_r  <= {(N+1){1'b0}};
`ifdef NLPRG_PERIOD_CHK_ONES_EN
            ones_r    <= {(N+1){1'b0}};
`endif
          end
        end
        ARM: begin
          if (valid_in) begin
            ref_r   <= o_in;
            prev_r  <= o_in;
            cnt_r   <= ONE;
            state_r <= RUN;
`ifdef NLPRG_PERIOD_CHK_ONES_EN
            ones_r  <= msb_s;
`endif
          end
        end
        RUN: begin
          // Return to ref wins over a repeat, so a period-1 sequence is not reported as stuck.
          if (valid_in) begin
            if (o_in == ref_r) begin
              period_r <= cnt_r;
              pass_r   <= (cnt_r == FULL) && ones_ok_s;
              done_r   <= 1'b1;
              busy_r   <= 1'b0;
              state_r  <= DONE;
            end else if (o_in == prev_r) begin
              stuck_r  <= 1'b1;
              period_r <= {(N+1){1'b0}};
              pass_r   <= 1'b0;
              done_r   <= 1'b1;
              busy_r   <= 1'b0;
              state_r  <= DONE;
            end else if (cnt_r == FULL) begin
              timeout_r <= 1'b1;
              period_r  <= {(N+1){1'b0}};
              pass_r    <= 1'b0;
              done_r    <= 1'b1;
              busy_r    <= 1'b0;
              state_r   <= DONE;
            end else begin
              cnt_r  <= cnt_r + ONE;
              prev_r <= o_in;
`ifdef NLPRG_PERIOD_CHK_ONES_EN
              ones_r <= ones_r + msb_s;
`endif
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nlprg_period_chk.sv
// Scoreboard bench for nlprg_period_chk: an N=4 instance for the corner cases and an N=16 instance for the full-period run.
module tb_nlprg_period_chk;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic        rst;
  logic        start4, v4;
  logic [3:0]  o4;
  logic        busy4, done4, pass4, stuck4, tmo4;
  logic [4:0]  period4;
  logic        start16, v16;
  logic [15:0] o16;
  logic        busy16, done16, pass16, stuck16, tmo16;
  logic [16:0] period16;
`ifdef NLPRG_PERIOD_CHK_ONES_EN
  logic [4:0]  ones4;
  logic [16:0] ones16;
`endif

  nlprg_period_chk #(.N(4)) u_chk4 (
    .ck(ck), .rst(rst), .start(start4), .valid_in(v4), .o_in(o4),
    .busy(busy4), .done(done4), .pass(pass4), .stuck(stuck4),
    .timeout(tmo4), .period(period4)
`ifdef NLPRG_PERIOD_CHK_ONES_EN
    , .ones_cnt(ones4)
`endif
  );

  nlprg_period_chk #(.N(16)) u_chk16 (
    .ck(ck), .rst(rst), .start(start16), .valid_in(v16), .o_in(o16),
    .busy(busy16), .done(done16), .pass(pass16), .stuck(stuck16),
    .timeout(tmo16), .period(period16)
`ifdef NLPRG_PERIOD_CHK_ONES_EN
    , .ones_cnt(ones16)
`endif
  );

  typedef struct {
    string name;
    int    period;
    bit    pass;
    bit    stuck;
    bit    tmo;
    int    ones;
    bit    full;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string nm, input int per, input bit ps, input bit st,
                          input bit tm, input int ones, input bit full);
    exp_t e;
    e.name = nm; e.period = per; e.pass = ps; e.stuck = st;
    e.tmo = tm; e.ones = ones; e.full = full;
    sb.push_back(e);
  endtask

  // Wait (bounded) for done on one instance, then compare against the oldest expectation.
  task automatic finish_run(input bit wide, input int budget);
    exp_t e;
    int   k;
    k = 0;
    while (!(wide ? done16 : done4) && k < budget) begin
      @(negedge ck);
      k++;
    end
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      if (wide) begin
        chk({e.name, "_done"},   {31'd0, done16},  32'd1);
        chk({e.name, "_busy"},   {31'd0, busy16},  32'd0);
        chk({e.name, "_period"}, {15'd0, period16}, e.period);
        chk({e.name, "_pass"},   {31'd0, pass16},  {31'd0, e.pass});
        chk({e.name, "_stuck"},  {31'd0, stuck16}, {31'd0, e.stuck});
        chk({e.name, "_tmo"},    {31'd0, tmo16},   {31'd0, e.tmo});
`ifdef NLPRG_PERIOD_CHK_ONES_EN
        if (e.full) chk({e.name, "_ones"}, {15'd0, ones16}, e.ones);
`endif
      end else begin
        chk({e.name, "_done"},   {31'd0, done4},  32'd1);
        chk({e.name, "_busy"},   {31'd0, busy4},  32'd0);
        chk({e.name, "_period"}, {27'd0, period4}, e.period);
        chk({e.name, "_pass"},   {31'd0, pass4},  {31'd0, e.pass});
        chk({e.name, "_stuck"},  {31'd0, stuck4}, {31'd0, e.stuck});
        chk({e.name, "_tmo"},    {31'd0, tmo4},   {31'd0, e.tmo});
`ifdef NLPRG_PERIOD_CHK_ONES_EN
        if (e.full) chk({e.name, "_ones"}, {27'd0, ones4}, e.ones);
`endif
      end
    end
  endtask

  // One measurement on the N=4 instance; gaps inserts an idle cycle after each sample and pulses start mid-run.
  task automatic run4(input string nm, input logic [3:0] seq[$], input bit gaps,
                      input int per, input bit ps, input bit st, input bit tm,
                      input int ones, input bit full);
    push_exp(nm, per, ps, st, tm, ones, full);
    @(negedge ck); start4 = 1'b1;
    @(negedge ck); start4 = 1'b0;
    chk({nm, "_busy_arm"}, {31'd0, busy4}, 32'd1);
    foreach (seq[i]) begin
      o4 = seq[i]; v4 = 1'b1;
      @(negedge ck);
      if (gaps) begin
        v4 = 1'b0; o4 = ~seq[i]; start4 = (i == 5);
        @(negedge ck);
        start4 = 1'b0;
      end
    end
    v4 = 1'b0;
    finish_run(1'b0, 20);
    // Samples arriving in DONE must not disturb the held result.
    o4 = 4'd9; v4 = 1'b1;
    @(negedge ck); @(negedge ck);
    v4 = 1'b0;
    chk({nm, "_hold"}, {27'd0, period4}, per);
  endtask

  logic [3:0]  q[$];
  logic [3:0]  x4;
  logic [15:0] x16;

  initial begin
    rst = 1'b0; start4 = 1'b0; v4 = 1'b0; o4 = 4'd0;
    start16 = 1'b0; v16 = 1'b0; o16 = 16'd0;
    @(negedge ck); @(negedge ck);
    chk("rst_busy",   {31'd0, busy16}, 32'd0);
    chk("rst_done",   {31'd0, done16}, 32'd0);
    chk("rst_period", {27'd0, period4}, 32'd0);
    rst = 1'b1;
    @(negedge ck);

    q = '{4'd3, 4'd5, 4'd5};
    run4("stuck", q, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0);

    q = '{4'd1, 4'd2, 4'd3, 4'd1};
    run4("short", q, 1'b0, 3, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    q = '{4'd7, 4'd7};
    run4("period1", q, 1'b0, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    q.delete();
    q.push_back(4'd0);
    for (int i = 0; i < 16; i++) q.push_back((i % 2 == 0) ? 4'd1 : 4'd2);
    run4("timeout", q, 1'b0, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0);

    // Full-period sequence x -> 5x+1 mod 16 visits all 16 values, 8 of them with MSB set.
    q.delete();
    x4 = 4'd0;
    for (int i = 0; i < 17; i++) begin
      q.push_back(x4);
      x4 = x4 * 4'd5 + 4'd1;
    end
    run4("gaps", q, 1'b1, 16, 1'b1, 1'b0, 1'b0, 8, 1'b1);

    // Wide instance: abort at cnt=100, then a fresh full-period run.
    @(negedge ck); start16 = 1'b1;
    @(negedge ck); start16 = 1'b0;
    x16 = 16'd0;
    for (int i = 0; i < 100; i++) begin
      o16 = x16; v16 = 1'b1;
      @(negedge ck);
      x16 = x16 * 16'd5 + 16'd1;
    end
    rst = 1'b0;
    #1;
    chk("abort_busy",   {31'd0, busy16},  32'd0);
    chk("abort_done",   {31'd0, done16},  32'd0);
    chk("abort_period", {15'd0, period16}, 32'd0);
    v16 = 1'b0;
    @(negedge ck);
    rst = 1'b1; start16 = 1'b1;
    push_exp("full16", 65536, 1'b1, 1'b0, 1'b0, 32768, 1'b1);
    @(negedge ck); start16 = 1'b0;
    chk("full16_busy_arm", {31'd0, busy16}, 32'd1);
    x16 = 16'd0;
    for (int i = 0; i < 65537; i++) begin
      o16 = x16; v16 = 1'b1;
      @(negedge ck);
      x16 = x16 * 16'd5 + 16'd1;
    end
    v16 = 1'b0;
    finish_run(1'b1, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
